// File: rtl/pe_dbuf_mac_if.sv
// Handshake/data bundle between a PE and its neighbours: activation, partial sum, weight chain, mode control.
// master drives the PE inputs; slave is the PE side.
interface pe_dbuf_mac_if #(
    parameter int DATA_W     = 8,
    parameter int DATA_W_OUT = 32
);
    logic                         valid_in;
    logic signed [DATA_W-1:0]     in_act;
    logic signed [DATA_W_OUT-1:0] in_psum;
    logic signed [DATA_W-1:0]     w_in_down;
    logic signed [DATA_W-1:0]     w_in_left;
    logic                         load_w;
    logic                         transpose_en;
    logic                         w_swap;
    logic                         acc_mode;
    logic                         acc_flush;
    logic signed [DATA_W-1:0]     out_act;
    logic signed [DATA_W_OUT-1:0] out_psum;
    logic signed [DATA_W-1:0]     w_out_up;
    logic signed [DATA_W-1:0]     w_out_right;
    logic                         valid_out;
    logic                         sat_flag;

    modport master (
        output valid_in, in_act, in_psum, w_in_down, w_in_left, load_w,
               transpose_en, w_swap, acc_mode, acc_flush,
        input  out_act, out_psum, w_out_up, w_out_right, valid_out, sat_flag
    );

    modport slave (
        input  valid_in, in_act, in_psum, w_in_down, w_in_left, load_w,
               transpose_en, w_swap, acc_mode, acc_flush,
        output out_act, out_psum, w_out_up, w_out_right, valid_out, sat_flag
    );
endinterface

// File: rtl/pe_dbuf_mac.sv
// Systolic PE: double-buffered weight, signed MAC with optional saturation, pass-down or local-accumulate mode.
// Latency: 1 cycle from valid_in to out_act/out_psum/valid_out; weight chain advances one hop per cycle.
// Backpressure: none; valid_in accepted every cycle.
module pe_dbuf_mac #(
    parameter int DATA_W     = 8,
    parameter int DATA_W_OUT = 32,
    parameter bit SAT_EN     = 1'b1
) (
    input logic          clk,
    input logic          rst,
    pe_dbuf_mac_if.slave pe
);
    localparam int PROD_W = 2 * DATA_W;
    localparam int SUM_W  = DATA_W_OUT + 1;
    localparam logic signed [DATA_W_OUT-1:0] PSUM_MAX = {1'b0, {(DATA_W_OUT-1){1'b1}}};
    localparam logic signed [DATA_W_OUT-1:0] PSUM_MIN = {1'b1, {(DATA_W_OUT-1){1'b0}}};

    logic signed [DATA_W-1:0]     w_shadow_q, w_shadow_d;
    logic signed [DATA_W-1:0]     w_active_q, w_active_d;
    logic signed [DATA_W_OUT-1:0] acc_q, acc_d;
    logic signed [DATA_W_OUT-1:0] out_psum_q, out_psum_d;
    logic signed [DATA_W-1:0]     out_act_q, out_act_d;
    logic                         valid_q, valid_d;
    logic                         sat_q, sat_d;

    logic signed [PROD_W-1:0]     prod;
    logic signed [DATA_W_OUT-1:0] prod_ext;
    logic signed [DATA_W_OUT-1:0] addend;
    logic signed [SUM_W-1:0]      sum_wide;
    logic signed [DATA_W_OUT-1:0] sum_val;
    logic                         sum_ovf;
    logic                         sum_sat;

    // One extra bit of headroom: overflow shows up as the top two bits disagreeing.
    assign prod     = PROD_W'(w_active_q) * PROD_W'(pe.in_act);
    assign prod_ext = DATA_W_OUT'(prod);
    assign addend   = pe.acc_mode ? acc_q : pe.in_psum;
    assign sum_wide = SUM_W'(addend) + SUM_W'(prod_ext);
    assign sum_ovf  = sum_wide[SUM_W-1] ^ sum_wide[SUM_W-2];

    always_comb begin
        sum_val = sum_wide[DATA_W_OUT-1:0];
        sum_sat = 1'b0;
        if (SAT_EN && sum_ovf) begin
            sum_val = sum_wide[SUM_W-1] ? PSUM_MIN : PSUM_MAX;
            sum_sat = 1'b1;
        end
    end

    always_comb begin
        w_shadow_d = pe.load_w ? (pe.transpose_en ? pe.w_in_left : pe.w_in_down) : w_shadow_q;
        // Swap reads the pre-edge shadow, so a same-cycle load lands only in the shadow.
        w_active_d = pe.w_swap ? w_shadow_q : w_active_q;
        acc_d      = acc_q;
        out_psum_d = out_psum_q;
        out_act_d  = out_act_q;
        valid_d    = 1'b0;
        sat_d      = sat_q;

        if (!pe.acc_mode) begin
            if (pe.valid_in) begin
                out_psum_d = sum_val;
                sat_d      = sum_sat;
                out_act_d  = pe.in_act;
                valid_d    = 1'b1;
            end
        end else begin
            if (pe.valid_in) begin
                acc_d     = sum_val;
                out_act_d = pe.in_act;
            end
            if (pe.acc_flush) begin
                out_psum_d = pe.valid_in ? sum_val : acc_q;
                sat_d      = pe.valid_in & sum_sat;
                acc_d      = '0;
                valid_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_shadow_q <= '0;
            w_active_q <= '0;
            acc_q      <= '0;
            out_psum_q <= '0;
            out_act_q  <= '0;
            valid_q    <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            w_shadow_q <= w_shadow_d;
            w_active_q <= w_active_d;
            acc_q      <= acc_d;
            out_psum_q <= out_psum_d;
            out_act_q  <= out_act_d;
            valid_q    <= valid_d;
            sat_q      <= sat_d;
        end
    end

    assign pe.out_act     = out_act_q;
    assign pe.out_psum    = out_psum_q;
    assign pe.w_out_up    = w_shadow_q;
    assign pe.w_out_right = w_shadow_q;
    assign pe.valid_out   = valid_q;
    assign pe.sat_flag    = sat_q;
endmodule

// File: tb/tb_pe_dbuf_mac.sv
// Bench for pe_dbuf_mac: a saturating and a wrapping 16-bit instance share stimulus; a behavioural model
// pushes expected outputs to a scoreboard each cycle, popped and compared one cycle later.
module tb_pe_dbuf_mac;
    localparam int DW   = 8;
    localparam int DWO  = 16;
    localparam int MAXV = (1 << (DWO - 1)) - 1;
    localparam int MINV = -(1 << (DWO - 1));

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pe_dbuf_mac_if #(.DATA_W(DW), .DATA_W_OUT(DWO)) ifs ();
    pe_dbuf_mac_if #(.DATA_W(DW), .DATA_W_OUT(DWO)) ifw ();

    pe_dbuf_mac #(.DATA_W(DW), .DATA_W_OUT(DWO), .SAT_EN(1'b1)) u_sat (.clk(clk), .rst(rst), .pe(ifs));
    pe_dbuf_mac #(.DATA_W(DW), .DATA_W_OUT(DWO), .SAT_EN(1'b0)) u_wrap (.clk(clk), .rst(rst), .pe(ifw));

    typedef struct {
        logic signed [DW-1:0]  act;
        logic signed [DW-1:0]  wout;
        logic signed [DWO-1:0] ps_s;
        logic signed [DWO-1:0] ps_w;
        logic                  sat_s;
        logic                  sat_w;
        logic                  vld;
    } exp_t;

    exp_t sb_q[$];
    exp_t m_out;
    int   m_wsh, m_wact, m_acc_s, m_acc_w;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int msum(input int a, input int b, input bit sat, output bit flag);
        int full;
        full = a + b;
        flag = 1'b0;
        if (sat) begin
            if (full > MAXV) begin full = MAXV; flag = 1'b1; end
            else if (full < MINV) begin full = MINV; flag = 1'b1; end
        end else begin
            while (full > MAXV) full -= (1 << DWO);
            while (full < MINV) full += (1 << DWO);
        end
        return full;
    endfunction

    task automatic step(input string tag, input bit v, input int act, input int psum,
                        input bit mode, input bit fl, input bit ld, input bit tr,
                        input int wd, input int wl, input bit sw);
        exp_t e;
        int   prod, ns, nw;
        bit   fs, fw;
        ifs.valid_in = v;      ifw.valid_in = v;
        ifs.in_act = DW'(act); ifw.in_act = DW'(act);
        ifs.in_psum = DWO'(psum); ifw.in_psum = DWO'(psum);
        ifs.acc_mode = mode;   ifw.acc_mode = mode;
        ifs.acc_flush = fl;    ifw.acc_flush = fl;
        ifs.load_w = ld;       ifw.load_w = ld;
        ifs.transpose_en = tr; ifw.transpose_en = tr;
        ifs.w_in_down = DW'(wd); ifw.w_in_down = DW'(wd);
        ifs.w_in_left = DW'(wl); ifw.w_in_left = DW'(wl);
        ifs.w_swap = sw;       ifw.w_swap = sw;

        e = m_out;
        ns = 0; nw = 0; fs = 1'b0; fw = 1'b0;
        if (rst) begin
            e = '{act: '0, wout: '0, ps_s: '0, ps_w: '0, sat_s: 1'b0, sat_w: 1'b0, vld: 1'b0};
            m_wsh = 0; m_wact = 0; m_acc_s = 0; m_acc_w = 0;
        end else begin
            prod  = m_wact * act;
            e.vld = 1'b0;
            if (!mode) begin
                if (v) begin
                    e.ps_s = DWO'(msum(psum, prod, 1'b1, fs)); e.sat_s = fs;
                    e.ps_w = DWO'(msum(psum, prod, 1'b0, fw)); e.sat_w = fw;
                    e.act  = DW'(act);
                    e.vld  = 1'b1;
                end
            end else begin
                if (v) begin
                    ns    = msum(m_acc_s, prod, 1'b1, fs);
                    nw    = msum(m_acc_w, prod, 1'b0, fw);
                    e.act = DW'(act);
                end
                if (fl) begin
                    e.ps_s  = DWO'(v ? ns : m_acc_s); e.sat_s = v & fs;
                    e.ps_w  = DWO'(v ? nw : m_acc_w); e.sat_w = v & fw;
                    e.vld   = 1'b1;
                    m_acc_s = 0; m_acc_w = 0;
                end else if (v) begin
                    m_acc_s = ns; m_acc_w = nw;
                end
            end
            if (sw) m_wact = m_wsh;
            if (ld) m_wsh = tr ? wl : wd;
            e.wout = DW'(m_wsh);
        end
        m_out = e;
        sb_q.push_back(e);

        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL %s: scoreboard empty got 0 expected 1 entry", tag);
        end else begin
            e = sb_q.pop_front();
            check({tag, ":act_s"},   ifs.out_act,     e.act);
            check({tag, ":act_w"},   ifw.out_act,     e.act);
            check({tag, ":psum_s"},  ifs.out_psum,    e.ps_s);
            check({tag, ":psum_w"},  ifw.out_psum,    e.ps_w);
            check({tag, ":sat_s"},   ifs.sat_flag,    e.sat_s);
            check({tag, ":sat_w"},   ifw.sat_flag,    e.sat_w);
            check({tag, ":vld_s"},   ifs.valid_out,   e.vld);
            check({tag, ":vld_w"},   ifw.valid_out,   e.vld);
            check({tag, ":wup"},     ifs.w_out_up,    e.wout);
            check({tag, ":wright"},  ifs.w_out_right, e.wout);
            check({tag, ":wup_w"},   ifw.w_out_up,    e.wout);
        end
    endtask

    initial begin
        m_wsh = 0; m_wact = 0; m_acc_s = 0; m_acc_w = 0;
        m_out = '{act: '0, wout: '0, ps_s: '0, ps_w: '0, sat_s: 1'b0, sat_w: 1'b0, vld: 1'b0};

        // tag, v, act, psum, mode, fl, ld, tr, wd, wl, sw
        rst = 1'b1;
        step("reset", 1, 9, 9, 0, 0, 1, 0, 9, 0, 1);
        rst = 1'b0;

        step("load5", 0, 0, 0, 0, 0, 1, 0, 5, 0, 0);
        check("anchor_wup5", ifs.w_out_up, 5);
        step("swap5", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step("mac90", 1, 10, 40, 0, 0, 0, 0, 0, 0, 0);
        check("anchor_90", ifs.out_psum, 90);
        check("anchor_90_vld", ifs.valid_out, 1);

        step("dbuf_ld3", 1, 2, 0, 0, 0, 1, 0, 3, 0, 0);
        check("anchor_10", ifs.out_psum, 10);
        step("dbuf_s1", 1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
        step("dbuf_sw", 1, 2, 0, 0, 0, 0, 0, 0, 0, 1);
        check("anchor_10_sw", ifs.out_psum, 10);
        step("dbuf_new", 1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
        check("anchor_6", ifs.out_psum, 6);
        step("ld7_sw", 1, 2, 0, 0, 0, 1, 0, 7, 0, 1);
        step("after_ld7", 1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
        check("anchor_act3", ifs.out_psum, 6);
        check("anchor_sh7", ifs.w_out_up, 7);

        step("tr_load", 0, 0, 0, 0, 0, 1, 1, 0, -4, 0);
        check("anchor_wr_m4", ifs.w_out_right, -4);
        step("tr_swap", 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
        step("tr_mac", 1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
        check("anchor_m12", ifs.out_psum, -12);

        step("sat_ld", 0, 0, 0, 0, 0, 1, 0, 127, 0, 0);
        step("sat_sw", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step("sat_pos", 1, 127, 32760, 0, 0, 0, 0, 0, 0, 0);
        check("anchor_sat", ifs.out_psum, 32767);
        check("anchor_satf", ifs.sat_flag, 1);
        check("anchor_wrap", ifw.out_psum, -16647);
        check("anchor_wrapf", ifw.sat_flag, 0);
        step("sat_neg", 1, -128, -32760, 0, 0, 0, 0, 0, 0, 0);
        check("anchor_satneg", ifs.out_psum, -32768);
        step("nosat", 1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
        step("bubble", 0, 77, 77, 0, 0, 0, 0, 0, 0, 0);

        step("acc_ld4", 0, 0, 0, 1, 0, 1, 0, 4, 0, 0);
        step("acc_sw4", 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
        step("acc_a1", 1, 1, 999, 1, 0, 0, 0, 0, 0, 0);
        step("acc_a2", 1, 2, 999, 1, 0, 0, 0, 0, 0, 0);
        step("acc_a3", 1, 3, 999, 1, 0, 0, 0, 0, 0, 0);
        step("acc_fl", 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        check("anchor_24", ifs.out_psum, 24);
        check("anchor_24_vld", ifs.valid_out, 1);
        step("acc_idle", 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        check("anchor_vld_1cyc", ifs.valid_out, 0);
        step("acc_flv", 1, 5, 0, 1, 1, 0, 0, 0, 0, 0);
        check("anchor_20", ifs.out_psum, 20);

        step("mode_a1", 1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        step("mode0_fl", 1, 1, 100, 0, 1, 0, 0, 0, 0, 0);
        check("anchor_104", ifs.out_psum, 104);
        step("mode1_fl", 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        check("anchor_keep4", ifs.out_psum, 4);

        step("rst_a1", 1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        step("rst_a2", 1, 2, 0, 1, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        step("rst_mid", 1, 3, 0, 1, 1, 1, 0, 9, 0, 1);
        rst = 1'b0;
        check("anchor_rst_psum", ifs.out_psum, 0);
        step("rst_fl", 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        check("anchor_rst_fl0", ifs.out_psum, 0);
        check("anchor_rst_flv", ifs.valid_out, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
